adder_sum_recover: RTL and testbench

- Inverse companion to the 6-bit prefix adder: takes a sum word `s` (7 bits) and one operand `y`, and recovers the other operand x = s - y.
- Flags sums that no valid 6-bit operand pair could have produced.
- Sits downstream of the adder result bus in the test/verification datapath.
- Two-stage pipelined subtractor with valid/ready handshake on both sides and full throughput.

---
 rtl/adder_sum_recover.sv | 105 ++++++++++
 tb/tb_adder_sum_recover.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_sum_recover.sv
// Recovers x = s - y from a (W+1)-bit adder sum and one W-bit operand, flagging
// sums no W-bit pair could produce. Define ADDER_RECOVER_ERRCNT_EN for err_cnt.
module adder_sum_recover #(
  parameter int W     = 6,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W:0]       s,
  input  logic [W-1:0]     y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     x,
  output logic             err
`ifdef ADDER_RECOVER_ERRCNT_EN
  ,
  output logic [CNT_W-1:0] err_cnt
`endif
);

  function automatic logic [W-1:0] f_recover(input logic signed [W+1:0] d);
    return d[W-1:0];
  endfunction

  // Borrow (s<y) or a difference that does not fit in W bits.
  function automatic logic f_inconsistent(input logic signed [W+1:0] d);
    return d[W+1] | d[W];
  endfunction

  logic signed [W+1:0] w_d_p0;
  logic                w_in_xfer;
  logic                w_adv_p2;
  logic                w_out_xfer;

  logic signed [W+1:0] r_d_p1;
  logic                r_vld_p1;
  logic [W-1:0]        r_x_p2;
  logic                r_err_p2;
  logic                r_vld_p2;

  assign w_d_p0     = $signed({1'b0, s}) - $signed({2'b00, y});
  assign w_adv_p2   = r_vld_p1 & (~r_vld_p2 | out_ready);
  assign in_ready   = ~rst & (~r_vld_p1 | w_adv_p2);
  assign w_in_xfer  = in_valid & in_ready;
  assign out_valid  = r_vld_p2 & ~rst;
  assign w_out_xfer = out_valid & out_ready;
  assign x          = r_x_p2;
  assign err        = r_err_p2;

  // ---- stage 1: capture the widened difference ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p1 <= 1'b0;
    end else if (w_in_xfer) begin
      r_vld_p1 <= 1'b1;
    end else if (w_adv_p2) begin
      r_vld_p1 <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_in_xfer) begin
      r_d_p1 <= w_d_p0;
    end
  end

  // ---- stage 2: recovered operand and consistency flag ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p2 <= 1'b0;
      r_x_p2   <= '0;
      r_err_p2 <= 1'b0;
    end else if (w_adv_p2) begin
      r_vld_p2 <= 1'b1;
      r_x_p2   <= f_recover(r_d_p1);
      r_err_p2 <= f_inconsistent(r_d_p1);
    end else if (out_ready) begin
      r_vld_p2 <= 1'b0;
    end
  end

`ifdef ADDER_RECOVER_ERRCNT_EN
  function automatic logic [CNT_W-1:0] f_sat_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
  endfunction

  logic [CNT_W-1:0] r_err_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_cnt <= '0;
    end else if (w_out_xfer && r_err_p2) begin
      r_err_cnt <= f_sat_inc(r_err_cnt);
    end
  end

  assign err_cnt = r_err_cnt;
`else
  logic w_unused;
  assign w_unused = w_out_xfer;
`endif

endmodule

// File: tb/tb_adder_sum_recover.sv
// Bench for adder_sum_recover: directed scenarios plus randomized traffic scored
// against an occupancy/arithmetic model. Define ADDER_RECOVER_ERRCNT_EN to cover err_cnt.
module tb_adder_sum_recover;
  localparam int W       = 6;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct {
    logic [W-1:0] x;
    logic         e;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [W:0]       s_in;
  logic [W-1:0]     y_in;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     x;
  logic             err;
`ifdef ADDER_RECOVER_ERRCNT_EN
  logic [CNT_W-1:0] err_cnt;
  int               smp_cnt;
`endif

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t q[$];
  exp_t cur;
  int   exp_cnt  = 0;
  logic smp_ir, smp_ov, smp_err, exp_ir, got_out, have_exp;
  logic [W-1:0] smp_x;

  adder_sum_recover #(.W(W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .s         (s_in),
    .y         (y_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .x         (x),
    .err       (err)
`ifdef ADDER_RECOVER_ERRCNT_EN
    ,
    .err_cnt   (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input int sv, input int yv);
    exp_t r;
    int   diff;
    diff = sv - yv;
    r.x  = W'(((diff % 64) + 64) % 64);
    r.e  = (diff < 0) || (diff > 63);
    return r;
  endfunction

  // One clock of stimulus; records samples and keeps the in-flight item queue.
  task automatic drive_cycle(input logic v, input int sv, input int yv, input logic ordy);
    in_valid  = v;
    s_in      = (W+1)'(sv);
    y_in      = W'(yv);
    out_ready = ordy;
    #1;
    smp_ir   = in_ready;
    smp_ov   = out_valid;
    smp_x    = x;
    smp_err  = err;
    exp_ir   = !rst && !(q.size() >= 2 && !ordy);
    got_out  = out_valid && out_ready;
    have_exp = 1'b0;
    if (got_out && q.size() > 0) begin
      cur = q.pop_front();
      have_exp = 1'b1;
      if (cur.e && exp_cnt < CNT_MAX) exp_cnt++;
    end
    if (in_valid && in_ready) q.push_back(model(sv, yv));
    @(posedge clk);
    #1;
    if (rst) begin
      q.delete();
      exp_cnt = 0;
    end
`ifdef ADDER_RECOVER_ERRCNT_EN
    smp_cnt = int'(err_cnt);
`endif
  endtask

  task automatic test_reset();
    in_valid = 1'b1; out_ready = 1'b1; s_in = '0; y_in = '0;
    #1;
    n_checks++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready got=%b want=0", in_ready); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b want=0", out_valid); else n_pass++;
    n_checks++; if (x !== 6'd0 || err !== 1'b0) $display("FAIL reset_data got x=%0d err=%b want 0/0", x, err); else n_pass++;
`ifdef ADDER_RECOVER_ERRCNT_EN
    n_checks++; if (err_cnt !== '0) $display("FAIL reset_err_cnt got=%0d want=0", err_cnt); else n_pass++;
`endif
    rst = 1'b0; in_valid = 1'b0;
    #1;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL post_reset_in_ready got=%b want=1", in_ready); else n_pass++;
  endtask

  task automatic test_single();
    drive_cycle(1'b1, 95, 40, 1'b1);
    n_checks++; if (smp_ir !== 1'b1) $display("FAIL single_accept got=%b want=1", smp_ir); else n_pass++;
    drive_cycle(1'b0, 0, 0, 1'b1);
    n_checks++; if (smp_ov !== 1'b0) $display("FAIL single_lat1 got out_valid=%b want=0", smp_ov); else n_pass++;
    drive_cycle(1'b0, 0, 0, 1'b1);
    n_checks++; if (smp_ov !== 1'b1) $display("FAIL single_lat2 got out_valid=%b want=1", smp_ov); else n_pass++;
    n_checks++; if (smp_x !== 6'd55 || smp_err !== 1'b0) $display("FAIL single_data got x=%0d err=%b want 55/0", smp_x, smp_err); else n_pass++;
    drive_cycle(1'b0, 0, 0, 1'b1);
    n_checks++; if (smp_ov !== 1'b0) $display("FAIL single_drain got out_valid=%b want=0", smp_ov); else n_pass++;
  endtask

  task automatic test_arith_edges();
    int ks[5] = '{10, 127, 126, 33, 0};
    int ky[5] = '{20, 0, 63, 33, 63};
    int kx[5] = '{54, 63, 63, 0, 1};
    int ke[5] = '{1, 1, 0, 0, 1};
    int i = 0;
    int k = 0;
    for (int c = 0; c < 16 && k < 5; c++) begin
      drive_cycle(i < 5, (i < 5) ? ks[i] : 0, (i < 5) ? ky[i] : 0, 1'b1);
      if (i < 5 && smp_ir) i++;
      if (got_out) begin
        n_checks++;
        if (smp_x !== W'(kx[k]) || smp_err !== 1'(ke[k]))
          $display("FAIL edge_item%0d got x=%0d err=%b want %0d/%0d", k, smp_x, smp_err, kx[k], ke[k]);
        else n_pass++;
        k++;
      end
    end
    n_checks++; if (k != 5) $display("FAIL edge_count got=%0d want=5", k); else n_pass++;
  endtask

  task automatic test_backpressure();
    int kx[3] = '{3, 5, 19};
    int k = 0;
    logic iv = 1'b1;
    drive_cycle(1'b1, 5, 2, 1'b0);
    n_checks++; if (smp_ir !== 1'b1) $display("FAIL bp_accept1 got=%b want=1", smp_ir); else n_pass++;
    drive_cycle(1'b1, 9, 4, 1'b0);
    n_checks++; if (smp_ir !== 1'b1) $display("FAIL bp_accept2 got=%b want=1", smp_ir); else n_pass++;
    for (int c = 0; c < 2; c++) begin
      drive_cycle(1'b1, 20, 1, 1'b0);
      n_checks++; if (smp_ir !== 1'b0) $display("FAIL bp_stall%0d got in_ready=%b want=0", c, smp_ir); else n_pass++;
      n_checks++; if (smp_ov !== 1'b1 || smp_x !== 6'd3) $display("FAIL bp_hold%0d got ov=%b x=%0d want 1/3", c, smp_ov, smp_x); else n_pass++;
    end
    for (int c = 0; c < 10 && k < 3; c++) begin
      drive_cycle(iv, 20, 1, 1'b1);
      if (iv && smp_ir) iv = 1'b0;
      if (got_out) begin
        n_checks++;
        if (smp_x !== W'(kx[k]) || smp_err !== 1'b0)
          $display("FAIL bp_order%0d got x=%0d err=%b want %0d/0", k, smp_x, smp_err, kx[k]);
        else n_pass++;
        k++;
      end
    end
    n_checks++; if (k != 3) $display("FAIL bp_count got=%0d want=3", k); else n_pass++;
  endtask

  task automatic test_reset_mid();
    drive_cycle(1'b1, 10, 20, 1'b0);
    drive_cycle(1'b1, 6, 6, 1'b0);
    rst = 1'b1;
    drive_cycle(1'b0, 0, 0, 1'b0);
    n_checks++; if (smp_ir !== 1'b0) $display("FAIL rstmid_in_ready got=%b want=0", smp_ir); else n_pass++;
    rst = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL rstmid_out_valid got=%b want=0", out_valid); else n_pass++;
`ifdef ADDER_RECOVER_ERRCNT_EN
    n_checks++; if (err_cnt !== '0) $display("FAIL rstmid_err_cnt got=%0d want=0", err_cnt); else n_pass++;
`endif
    drive_cycle(1'b1, 1, 1, 1'b1);
    n_checks++; if (smp_ov !== 1'b0) $display("FAIL rstmid_flushed got out_valid=%b want=0", smp_ov); else n_pass++;
    drive_cycle(1'b0, 0, 0, 1'b1);
    drive_cycle(1'b0, 0, 0, 1'b1);
    n_checks++;
    if (smp_ov !== 1'b1 || smp_x !== 6'd0 || smp_err !== 1'b0)
      $display("FAIL rstmid_first got ov=%b x=%0d err=%b want 1/0/0", smp_ov, smp_x, smp_err);
    else n_pass++;
  endtask

`ifdef ADDER_RECOVER_ERRCNT_EN
  task automatic test_err_cnt_sat();
    int kc[5] = '{1, 2, 3, 3, 3};
    int i = 0;
    int k = 0;
    rst = 1'b1;
    drive_cycle(1'b0, 0, 0, 1'b1);
    rst = 1'b0;
    for (int c = 0; c < 20 && k < 5; c++) begin
      drive_cycle(i < 5, 10, 20, 1'b1);
      if (i < 5 && smp_ir) i++;
      if (got_out) begin
        n_checks++;
        if (smp_cnt != kc[k]) $display("FAIL errcnt_step%0d got=%0d want=%0d", k, smp_cnt, kc[k]);
        else n_pass++;
        k++;
      end
    end
    n_checks++; if (k != 5) $display("FAIL errcnt_count got=%0d want=5", k); else n_pass++;
  endtask
`endif

  task automatic test_random();
    logic v, ordy, prev_stall;
    logic [W-1:0] prev_x;
    logic prev_err;
    int sv, yv;
    prev_stall = 1'b0; prev_x = '0; prev_err = 1'b0;
    for (int c = 0; c < 400; c++) begin
      v    = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      case ($urandom_range(0, 5))
        0: begin sv = 127; yv = $urandom_range(0, 63); end
        1: begin yv = $urandom_range(0, 63); sv = yv; end
        default: begin sv = $urandom_range(0, 127); yv = $urandom_range(0, 63); end
      endcase
      drive_cycle(v, sv, yv, ordy);
      n_checks++; if (smp_ir !== exp_ir) $display("FAIL rnd_in_ready c=%0d got=%b want=%b", c, smp_ir, exp_ir); else n_pass++;
      if (prev_stall) begin
        n_checks++;
        if (smp_ov !== 1'b1 || smp_x !== prev_x || smp_err !== prev_err)
          $display("FAIL rnd_hold c=%0d got ov=%b x=%0d err=%b want 1/%0d/%b", c, smp_ov, smp_x, smp_err, prev_x, prev_err);
        else n_pass++;
      end
      if (got_out) begin
        n_checks++;
        if (!have_exp || smp_x !== cur.x || smp_err !== cur.e)
          $display("FAIL rnd_data c=%0d got x=%0d err=%b want %0d/%b (queued=%b)", c, smp_x, smp_err, cur.x, cur.e, have_exp);
        else n_pass++;
      end
`ifdef ADDER_RECOVER_ERRCNT_EN
      n_checks++; if (smp_cnt != exp_cnt) $display("FAIL rnd_err_cnt c=%0d got=%0d want=%0d", c, smp_cnt, exp_cnt); else n_pass++;
`endif
      prev_stall = smp_ov && !ordy;
      prev_x     = smp_x;
      prev_err   = smp_err;
    end
    for (int c = 0; c < 8; c++) begin
      drive_cycle(1'b0, 0, 0, 1'b1);
      if (got_out) begin
        n_checks++;
        if (!have_exp || smp_x !== cur.x || smp_err !== cur.e)
          $display("FAIL rnd_drain got x=%0d err=%b want %0d/%b", smp_x, smp_err, cur.x, cur.e);
        else n_pass++;
      end
    end
    n_checks++; if (q.size() != 0 || out_valid !== 1'b0) $display("FAIL rnd_empty got left=%0d ov=%b want 0/0", q.size(), out_valid); else n_pass++;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; s_in = '0; y_in = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_arith_edges();
    test_backpressure();
    test_reset_mid();
`ifdef ADDER_RECOVER_ERRCNT_EN
    test_err_cnt_sat();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
